// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and coordinate type for the video path.
// Reused by vga_timing_gen and the pixel-coordinate calculator.
package vga_pkg;

  localparam int unsigned COORD_W = 10;

  typedef logic [COORD_W-1:0] vga_coord_t;

  localparam int unsigned VGA_H_SYNC = 96;
  localparam int unsigned VGA_H_BP   = 48;
  localparam int unsigned VGA_H_ACT  = 640;
  localparam int unsigned VGA_H_FP   = 16;
  localparam int unsigned VGA_V_SYNC = 2;
  localparam int unsigned VGA_V_BP   = 11;
  localparam int unsigned VGA_V_ACT  = 480;
  localparam int unsigned VGA_V_FP   = 32;

  localparam int unsigned H_TOTAL = VGA_H_SYNC + VGA_H_BP + VGA_H_ACT + VGA_H_FP;
  localparam int unsigned V_TOTAL = VGA_V_SYNC + VGA_V_BP + VGA_V_ACT + VGA_V_FP;

  // Active window as half-open ranges [start, end) in raw counter space.
  localparam int unsigned H_ACT_START = VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned H_ACT_END   = H_ACT_START + VGA_H_ACT;
  localparam int unsigned V_ACT_START = VGA_V_SYNC + VGA_V_BP;
  localparam int unsigned V_ACT_END   = V_ACT_START + VGA_V_ACT;

  function automatic vga_coord_t to_coord(int unsigned v);
    return vga_coord_t'(v);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Generic wrapping raster counter with registered sync and active-window decode.
// Decode is taken from the next-state count so it always matches count_o.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned Total    = H_TOTAL,
  parameter int unsigned SyncLen  = VGA_H_SYNC,
  parameter int unsigned ActStart = H_ACT_START,
  parameter int unsigned ActEnd   = H_ACT_END,
  parameter logic        SyncPol  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic [9:0] count_o,
  output logic       last_o,
  output logic       sync_o,
  output logic       act_o
);

  localparam vga_coord_t LastC     = to_coord(Total - 1);
  localparam vga_coord_t SyncLenC  = to_coord(SyncLen);
  localparam vga_coord_t ActStartC = to_coord(ActStart);
  localparam vga_coord_t ActEndC   = to_coord(ActEnd);

  vga_coord_t count_q, count_d;
  logic       sync_q, sync_d;
  logic       act_q, act_d;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == LastC) ? '0 : count_q + 10'd1;
    end
    sync_d = (count_d < SyncLenC) ? SyncPol : ~SyncPol;
    act_d  = (count_d >= ActStartC) && (count_d < ActEndC);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      sync_q  <= SyncPol;
      act_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
      act_q   <= act_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == LastC);
  assign sync_o  = sync_q;
  assign act_o   = act_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: counters, syncs, active flag, line/frame strobes.
// Define VGA_TIMING_GEN_PIXDIV_EN to derive a half-rate pix_en from clk.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned H_ACT    = VGA_H_ACT,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned V_ACT    = VGA_V_ACT,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       pix_en,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned HTotal    = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned VTotal    = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int unsigned HActStart = H_SYNC + H_BP;
  localparam int unsigned VActStart = V_SYNC + V_BP;

  logic pix_en_q, pix_en_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;
  logic h_last, v_last;
  logic h_act, v_act;
  logic v_en;

  assign v_en = pix_en_q & h_last;

  vga_axis_counter #(
    .Total    (HTotal),
    .SyncLen  (H_SYNC),
    .ActStart (HActStart),
    .ActEnd   (HActStart + H_ACT),
    .SyncPol  (SYNC_POL)
  ) u_h_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (pix_en_q),
    .count_o (x),
    .last_o  (h_last),
    .sync_o  (hsync),
    .act_o   (h_act)
  );

  vga_axis_counter #(
    .Total    (VTotal),
    .SyncLen  (V_SYNC),
    .ActStart (VActStart),
    .ActEnd   (VActStart + V_ACT),
    .SyncPol  (SYNC_POL)
  ) u_v_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (v_en),
    .count_o (y),
    .last_o  (v_last),
    .sync_o  (vsync),
    .act_o   (v_act)
  );

  always_comb begin
`ifdef VGA_TIMING_GEN_PIXDIV_EN
    pix_en_d = ~pix_en_q;
`else
    pix_en_d = 1'b1;
`endif
    // Strobes follow the pixel they belong to, so they only change on an advance.
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (pix_en_q) begin
      line_start_d  = h_last;
      frame_start_d = h_last & v_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_en_q      <= pix_en_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Both window flags are flops fed from next-state counts.
  assign active      = h_act & v_act;
  assign pix_en      = pix_en_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running 640x480@60 Hz VGA raster generator. Produces raw horizontal/vertical counters `x`/`y` (the coordinate space consumed by the pixel-coordinate calculator), `hsync`/`vsync`, an active-video flag, and line/frame start strobes. Sits at the head of the video path, driven by the system clock, feeding coordinate calculation and the VGA pins.

## Interface
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BP`, 48: horizontal back porch.
- `H_ACT`, 640: horizontal active pixels.
- `H_FP`, 16: horizontal front porch.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BP`, 11: vertical back porch.
- `V_ACT`, 480: active lines.
- `V_FP`, 32: vertical front porch.
- `SYNC_POL`, 0: asserted level of `hsync`/`vsync`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `x` out 10: horizontal counter, 0..H_TOTAL-1, where H_TOTAL = 800.
- `y` out 10: vertical counter, 0..V_TOTAL-1, where V_TOTAL = 525.
- `hsync` out 1: asserted (`SYNC_POL`) while x < H_SYNC.
- `vsync` out 1: asserted while y < V_SYNC.
- `active` out 1: high while x in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT) and y in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT).
- `pix_en` out 1: high when the next `clk` edge advances the raster.
- `line_start` out 1: high for the pixel period in which x==0, after a wrap.
- `frame_start` out 1: high for the pixel period in which x==0 and y==0, after a wrap.

## Operation
- Counter pair: x increments on each advance. When x reaches H_TOTAL-1, the next advance sets x=0 and increments y. When y also reaches V_TOTAL-1, y wraps to 0.
- Counters advance only on edges where `pix_en`==1 and `rst_n`==1.
- `hsync`, `vsync`, `active`, `line_start` and `frame_start` are registered. They are computed from the next-state counter values, so on every cycle they are consistent with the `x`/`y` visible on that cycle. They are never delayed by one pixel.
- Default vertical window gives active lines y = 13..492. Horizontal active is x = 144..783.
- Reset values:
  - x=0, y=0.
  - hsync=SYNC_POL, vsync=SYNC_POL (consistent with position 0,0).
  - active=0, pix_en=0.
  - line_start=0, frame_start=0. Strobes are not asserted for the post-reset (0,0); they assert only on wraps.
- Reset mid-frame: the next edge with `rst_n`==0 forces all reset values regardless of position or divider phase. There is no partial line.
- Arithmetic: all comparisons are unsigned on 10 bits. Totals are computed in localparams. Parameter sets with a total greater than 1023 are illegal and are not checked.

## Timing
- No-divide build: `pix_en` goes to 1 on the first edge with `rst_n`==1 and stays 1. The raster advances from the second edge with `rst_n`==1, then one pixel per clk.
- Divide build: `pix_en` toggles every clk, starting at 0→1 on the first non-reset edge. The raster advances on every edge where `pix_en`==1, i.e. one pixel per 2 clk.
- Each pixel period, the state (x, y, syncs, active, strobes) holds for exactly 1 clk (no-divide) or 2 clk (divide).
- Line period: 800 pixel periods. Frame period: 420000 pixel periods.
- `line_start` and `frame_start` are asserted in the same pixel period at a frame wrap.

## Configuration
- Macro: `VGA_TIMING_GEN_PIXDIV_EN`.
  - Defined: internal divide-by-2 toggle generates `pix_en`, for a 50 MHz `clk` giving a 25 MHz pixel rate.
  - Undefined: `clk` is the pixel clock and `pix_en` is held at 1 out of reset.
- All other behaviour is identical in both builds.

## Structure
- Shared package `vga_pkg` holds the default timing constants (the 8 porch/sync/active values), H_TOTAL/V_TOTAL, the derived active-window bounds, and the 10-bit coordinate typedef `vga_coord_t`. These are reused by the coordinate calculator.
- One natural sub-module: `vga_axis_counter`, a generic wrapping counter with sync/active window decode. It is instantiated once for horizontal (enable = pix_en) and once for vertical (enable = pix_en & horizontal wrap).

## Test plan
- Reset held 5 clk, then released (no-divide) → x=0,y=0, hsync=vsync=0, active=0 during reset; x=1 after the 2nd non-reset edge; no strobe at start.
- Run 800 pixels → x=799 then x=0,y=1 with `line_start`=1 for exactly 1 clk; hsync low exactly for x=0..95.
- Run to y=13,x=144 → `active` rises on the same cycle x=144 is visible; falls at x=784; first and last active lines are y=13 and y=492.
- Full frame → y=524,x=799 wraps to (0,0) with `frame_start`=`line_start`=1; vsync low for y=0..1; 420000 pixels per frame.
- Divide build → `pix_en` alternates 0/1, each x value held 2 clk, frame = 840000 clk.
- Assert `rst_n`=0 at x=400,y=200, mid divider phase → next edge: all outputs at reset values; resume matches the post-reset sequence.
